upsample_2x2: RTL



---
 rtl/upsample_2x2.sv | 57 +++++
 1 files changed

// File: rtl/upsample_2x2.sv
// upsample_2x2: 2x2 row upsampler (pooled row in on s_*, two R-wide rows out on m_*, m_odd marks the second row)
module upsample_2x2 #(
    parameter int R         = 10,
    parameter int W         = 8,
    parameter int ZERO_FILL = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [R/2-1:0][W-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [R-1:0][W-1:0]     m_data,
    output logic                    m_odd
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] TX0   = 2'd1;
    localparam logic [1:0] TX1   = 2'd2;
    localparam bit         ZF    = ZERO_FILL != 0;

    if (R < 2 || R % 2 != 0) begin : g_bad_r
        $error("upsample_2x2: R must be even and >= 2");
    end

    logic [1:0]             state, state_d;
    logic [R/2-1:0][W-1:0]  row_q;

    assign s_ready = !rst && (state == EMPTY || (state == TX1 && m_ready));
    assign m_valid = state != EMPTY;
    assign m_odd   = state == TX1;

    always_comb begin
        state_d = state == EMPTY ? (s_valid ? TX0 : EMPTY) :
                  state == TX0   ? (m_ready ? TX1 : TX0) :
                  !m_ready       ? TX1 :
                  s_valid        ? TX0 : EMPTY;
    end

    always_comb begin
        m_data = '0;
        for (int c = 0; c < R/2; c++) begin
            m_data[2*c]   = (state == EMPTY || (ZF && state == TX1)) ? '0 : row_q[c];
            m_data[2*c+1] = (state == EMPTY || ZF) ? '0 : row_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            row_q <= '0;
        end else begin
            state <= state_d;
            if (s_valid && s_ready) row_q <= s_data;
        end
    end
endmodule
